// File: rtl/uart_pkg.sv
// UART shared definitions: receiver states, word-length codes
// and LCR bit positions common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int unsigned LCR_WLS_LO = 0;
  localparam int unsigned LCR_WLS_HI = 1;
  localparam int unsigned LCR_STB    = 2;
  localparam int unsigned LCR_PEN    = 3;
  localparam int unsigned LCR_EPS    = 4;
  localparam int unsigned LCR_SP     = 5;
  localparam int unsigned LCR_BC     = 6;

  // Bits arrive LSB first into the top of the shifter.
  function automatic logic [7:0] rx_align(
    input logic [7:0] sr,
    input logic [1:0] wls
  );
    logic [7:0] r;
    r = sr;
    unique case (wls)
      WLS_5: r = {3'b000, sr[7:3]};
      WLS_6: r = {2'b00, sr[7:2]};
      WLS_7: r = {1'b0, sr[7:1]};
      WLS_8: r = sr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and the RX FIFO.
interface uart_rx_if;

  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       perr_o;
  logic       ferr_o;
  logic       brk_o;
  logic       overrun_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    output perr_o,
    output ferr_o,
    output brk_o,
    output overrun_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    input  perr_o,
    input  ferr_o,
    input  brk_o,
    input  overrun_o,
    output rx_ready_i
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module uart_sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing
// with a single-entry valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  output logic       busy_o,
  uart_rx_if.master  out_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

  logic            line;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [1:0]      wls_q;
  logic            pen_q;
  logic            eps_q;
  logic            par_q;
  logic            perr_q;

  logic [7:0]      data_q;
  logic            vld_q;
  logic            operr_q;
  logic            oferr_q;
  logic            obrk_q;
  logic            ovr_q;

  logic [7:0]      frame_data;
  logic            stop_hit;
  logic            frame_brk;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (line)
  );

  assign frame_data = rx_align(shift_q, wls_q);
  assign stop_hit   = baud_tick_i && (state_q == RX_STOP)
                    && (cnt_q == FULL);
  assign frame_brk  = (frame_data == 8'h00)
                    && !(pen_q && par_q) && !line;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wls_q   <= WLS_5;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else if (baud_tick_i) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!line) begin
            state_q <= RX_START;
            cnt_q   <= '0;
            shift_q <= '0;
            wls_q   <= wls_i;
            pen_q   <= pen_i;
            eps_q   <= eps_i;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {line, shift_q[7:1]};
            // Last bit index is 4 + wls for 5..8 bit words.
            if (bit_q == {1'b1, wls_q}) begin
              state_q <= pen_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            par_q   <= line;
            perr_q  <= (^shift_q) ^ line ^ !eps_q;
            state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      vld_q   <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      obrk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (stop_hit) begin
        if (vld_q && !out_if.rx_ready_i) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= frame_data;
          operr_q <= pen_q & perr_q;
          oferr_q <= !line;
          obrk_q  <= frame_brk;
          vld_q   <= 1'b1;
        end
      end else if (vld_q && out_if.rx_ready_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign busy_o            = (state_q != RX_IDLE);
  assign out_if.rx_data_o  = data_q;
  assign out_if.rx_valid_o = vld_q;
  assign out_if.perr_o     = operr_q;
  assign out_if.ferr_o     = oferr_q;
  assign out_if.brk_o      = obrk_q;
  assign out_if.overrun_o  = ovr_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud ticks per bit period (must be even, >= 8).
REQ-002 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port baud_tick_i  in  1  one-cycle enable pulse at OVERSAMPLE x baud rate, from the shared baud generator.
REQ-005 SHALL have port rx_i  in  1  asynchronous serial line; idle high.
REQ-006 SHALL have port wls_i  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits (LCR[1:0]).
REQ-007 SHALL have port pen_i  in  1  parity enable (LCR[3]).
REQ-008 SHALL have port eps_i  in  1  even parity select when 1, odd when 0 (LCR[4]).
REQ-009 SHALL have port rx_data_o  out  8  received byte, zero-extended above word length.
REQ-010 SHALL have port rx_valid_o  out  1  rx_data_o and error flags hold a byte.
REQ-011 SHALL have port rx_ready_i  in  1  RX FIFO accepts the byte (not full).
REQ-012 SHALL have port perr_o / ferr_o / brk_o  out  1 each  parity, framing, break flags qualified by rx_valid_o.
REQ-013 SHALL have port overrun_o  out  1  one-cycle pulse when a completed byte is dropped.
REQ-014 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer, both flops reset to 1; all sampling uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; a tick counter counts baud_tick_i only.
REQ-017 IDLE: on a baud_tick_i where the synchronized line is 0, SHALL enter START with counter cleared and latch wls_i, pen_i, eps_i for the whole frame.
REQ-018 START: at tick OVERSAMPLE/2, line 0 -> DATA with counter cleared; line 1 -> IDLE (false start, no output).
REQ-019 DATA: SHALL sample every OVERSAMPLE ticks (bit mid-point), LSB first, shifting into an 8-bit register; after 5+wls bits -> PARITY if pen latched, else STOP.
REQ-020 PARITY: SHALL sample one bit; perr = (XOR of data bits XOR parity bit) != eps (i.e. even: XOR of all must be 0; odd: must be 1).
REQ-021 STOP: SHALL sample one bit; ferr = (bit == 0); brk = data, parity (if enabled) and stop bits all 0; then SHALL return to IDLE on the same cycle (mid-stop, allowing resync); only the first stop bit is checked.
REQ-022 SHALL load rx_data_o/flags and assert rx_valid_o the cycle after the stop-bit sample tick.
REQ-023 rx_valid_o SHALL remain high with data/flags stable until a cycle with rx_ready_i=1; it deasserts the following cycle unless a new byte loads the same cycle.
REQ-024 If a byte completes while rx_valid_o=1 and rx_ready_i=0, SHALL drop the new byte, keep the held byte, and pulse overrun_o for one cycle.
REQ-025 If a byte completes in the same cycle the held byte is accepted, SHALL load the new byte with rx_valid_o staying high and no overrun.
REQ-026 baud_tick_i low SHALL freeze the counter and state (except load/handshake logic).

Reset
REQ-027 On rst: state IDLE, counter 0, shift register 0, synchronizer flops 1.
REQ-028 On rst: rx_data_o 0, rx_valid_o 0, perr_o/ferr_o/brk_o 0, overrun_o 0, busy_o 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output; reception resumes on the next start bit after release.

Structure
REQ-030 Package uart_pkg SHALL hold the rx state enum, the word-length encodings and the LCR bit-position constants shared with the transmitter.
REQ-031 The synchronizer SHALL be a separate sub-module uart_sync2 (parameterized reset value), reused elsewhere in io.

Verification
REQ-032 8N1 frame 0x55 at OVERSAMPLE=16, rx_ready_i=1 -> one rx_valid_o with rx_data_o=0x55, all flags 0.
REQ-033 7E1 frame data 0x41 with parity bit 1 (wrong) -> rx_data_o=0x41, perr_o=1; same frame with parity 0 -> perr_o=0.
REQ-034 8N1 0xA3 with stop bit 0 -> ferr_o=1; all-zero frame held low for 2 frames -> brk_o=1, ferr_o=1, rx_data_o=0x00.
REQ-035 Low glitch of 4 ticks on idle line -> no rx_valid_o, busy_o returns to 0 after 8 ticks.
REQ-036 Two frames 0x11, 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11, overrun_o pulses once; raising rx_ready_i drains 0x11 only.
REQ-037 rst asserted during DATA of 0xFF, then clean 0x3C -> only 0x3C delivered.
